// File: rtl/bp_me_mem_port_arbiter.sv
// Two-requester BedRock memory port arbiter.
// Commands from two cache engines are merged round-robin onto one memory
// port. The source of every accepted command is pushed into a small order
// FIFO. Responses come back in command order and are steered to the
// requester at the FIFO head.
module bp_me_mem_port_arbiter #(
  parameter int msg_width_p       = 512,
  parameter int max_outstanding_p = 4,
  localparam int lg_outstanding_lp = $clog2(max_outstanding_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,

  input  logic [2*msg_width_p-1:0]     cmd_i,
  input  logic [1:0]                   cmd_v_i,
  output logic [1:0]                   cmd_ready_o,

  output logic [msg_width_p-1:0]       resp_o,
  output logic [1:0]                   resp_v_o,
  input  logic [1:0]                   resp_yumi_i,

  output logic [msg_width_p-1:0]       mem_cmd_o,
  output logic                         mem_cmd_v_o,
  input  logic                         mem_cmd_ready_i,

  input  logic [msg_width_p-1:0]       mem_resp_i,
  input  logic                         mem_resp_v_i,
  output logic                         mem_resp_yumi_o,

  output logic [lg_outstanding_lp-1:0] outstanding_o,
  output logic                         error_o
);

  localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam logic [ptr_width_lp-1:0]      last_ptr_lp = ptr_width_lp'(max_outstanding_p - 1);
  localparam logic [lg_outstanding_lp-1:0] full_cnt_lp = lg_outstanding_lp'(max_outstanding_p);

  logic [max_outstanding_p-1:0]  ids_r;
  logic [ptr_width_lp-1:0]       rptr_r;
  logic [ptr_width_lp-1:0]       wptr_r;
  logic [lg_outstanding_lp-1:0]  count_r;
  logic                          rr_r;
  logic                          error_r;
  logic                          quiet_r;

  logic quiet;
  logic full;
  logic fv;
  logic both_v;
  logic gnt;
  logic head;
  logic cmd_ok;
  logic resp_v;
  logic enq;
  logic deq;
  logic err_evt;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + 1'b1;
  endfunction

  // Grant selection, command merge and response steering; the port stays
  // silent during reset and the first cycle after it.
  always_comb begin
    quiet   = reset_i | quiet_r;
    full    = (count_r == full_cnt_lp);
    fv      = (count_r != '0);
    both_v  = &cmd_v_i;
    gnt     = both_v ? rr_r : cmd_v_i[1];
    head    = ids_r[rptr_r];

    cmd_ok      = mem_cmd_ready_i & ~full & ~quiet;
    mem_cmd_v_o = (|cmd_v_i) & ~full & ~quiet;
    mem_cmd_o   = gnt ? cmd_i[2*msg_width_p-1:msg_width_p] : cmd_i[msg_width_p-1:0];
    cmd_ready_o = {cmd_ok & gnt, cmd_ok & ~gnt};

    resp_v          = mem_resp_v_i & fv & ~quiet;
    resp_o          = mem_resp_i;
    resp_v_o        = {resp_v & head, resp_v & ~head};
    mem_resp_yumi_o = resp_v & (head ? resp_yumi_i[1] : resp_yumi_i[0]);

    enq     = mem_cmd_v_o & mem_cmd_ready_i;
    deq     = mem_resp_yumi_o;
    err_evt = ~quiet & ((mem_resp_v_i & ~fv) | (|(resp_yumi_i & ~resp_v_o)));

    outstanding_o = reset_i ? '0 : count_r;
    error_o       = reset_i ? 1'b0 : error_r;
  end

  // Order FIFO storage: source ID of each accepted command.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      ids_r[wptr_r] <= gnt;
    end
  end

  // FIFO pointers and occupancy, round-robin pointer, sticky error flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
      rr_r    <= 1'b0;
      error_r <= 1'b0;
      quiet_r <= 1'b1;
    end else begin
      quiet_r <= 1'b0;
      if (enq) begin
        wptr_r <= ptr_inc(wptr_r);
      end
      if (deq) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      if (enq & ~deq) begin
        count_r <= count_r + 1'b1;
      end else if (deq & ~enq) begin
        count_r <= count_r - 1'b1;
      end
      if (enq & both_v) begin
        rr_r <= ~gnt;
      end
      if (err_evt) begin
        error_r <= 1'b1;
      end
    end
  end

endmodule
